alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: single-cycle codes pass through with one cycle of latency; DIVU
// (and MULTU when ALU_SEQ_MULTU_EN is defined) runs DATA_W cycles, then strobes HI/LO.
module alu_op_sequencer #(
  parameter int               DATA_W    = 32,
  parameter int               SIG_W     = 6,
  parameter logic [SIG_W-1:0] NOP_CODE  = 6'b000000,
  parameter logic [SIG_W-1:0] HILO_CODE = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIG_W-1:0] signal_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             flush_in,
  output logic [SIG_W-1:0] ctrl_alu,
  output logic [SIG_W-1:0] ctrl_sht,
  output logic [SIG_W-1:0] ctrl_div,
  output logic [SIG_W-1:0] ctrl_mux,
  output logic             hilo_we,
  output logic             busy,
  output logic             start_pulse
);

  localparam int               CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [SIG_W-1:0] DIVU_CODE = SIG_W'(27);
`ifdef ALU_SEQ_MULTU_EN
  localparam logic [SIG_W-1:0] MULTU_CODE = SIG_W'(25);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] ctrl;

  function automatic logic is_iter(input logic [SIG_W-1:0] code);
`ifdef ALU_SEQ_MULTU_EN
    return (code == DIVU_CODE) || (code == MULTU_CODE);
`else
    return (code == DIVU_CODE);
`endif
  endfunction

  assign ready_out = (state == IDLE);
  assign ctrl_alu  = ctrl;
  assign ctrl_sht  = ctrl;
  assign ctrl_div  = ctrl;
  assign ctrl_mux  = ctrl;

  // Sequencer FSM with registered control code and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      ctrl        <= NOP_CODE;
      hilo_we     <= 1'b0;
      busy        <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= {CNT_W{1'b0}};
          hilo_we <= 1'b0;
          if (valid_in && !flush_in) begin
            ctrl <= signal_in;
            if (is_iter(signal_in)) begin
              state       <= RUN;
              busy        <= 1'b1;
              start_pulse <= 1'b1;
            end else begin
              state       <= IDLE;
              busy        <= 1'b0;
              start_pulse <= 1'b0;
            end
          end else begin
            state       <= IDLE;
            ctrl        <= NOP_CODE;
            busy        <= 1'b0;
            start_pulse <= 1'b0;
          end
        end
        RUN: begin
          start_pulse <= 1'b0;
          if (flush_in) begin
            state   <= IDLE;
            cnt     <= {CNT_W{1'b0}};
            ctrl    <= NOP_CODE;
            hilo_we <= 1'b0;
            busy    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            // last run cycle: next cycle presents the HI/LO write
            state   <= DONE;
            cnt     <= {CNT_W{1'b0}};
            ctrl    <= HILO_CODE;
            hilo_we <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state   <= RUN;
            cnt     <= cnt + CNT_W'(1);
            hilo_we <= 1'b0;
            busy    <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          cnt         <= {CNT_W{1'b0}};
          ctrl        <= NOP_CODE;
          hilo_we     <= 1'b0;
          busy        <= 1'b0;
          start_pulse <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cnt         <= {CNT_W{1'b0}};
          ctrl        <= NOP_CODE;
          hilo_we     <= 1'b0;
          busy        <= 1'b0;
          start_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a timeline model pushes the expected
// per-cycle outputs, and a negedge monitor pops and compares them.
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam logic [5:0] NOP = 6'd0;
  localparam logic [5:0] HILO = 6'd63;
  localparam logic [5:0] C_ADD = 6'd32;
  localparam logic [5:0] C_AND = 6'd36;
  localparam logic [5:0] C_DIVU = 6'd27;
  localparam logic [5:0] C_MULTU = 6'd25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] signal_in = 6'd0;
  logic       valid_in = 1'b0;
  logic       flush_in = 1'b0;
  logic       ready_out, hilo_we, busy, start_pulse;
  logic [5:0] ctrl_alu, ctrl_sht, ctrl_div, ctrl_mux;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .valid_in(valid_in),
    .ready_out(ready_out), .flush_in(flush_in), .ctrl_alu(ctrl_alu),
    .ctrl_sht(ctrl_sht), .ctrl_div(ctrl_div), .ctrl_mux(ctrl_mux),
    .hilo_we(hilo_we), .busy(busy), .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       hilo;
    logic       bsy;
    logic       start;
    logic       ready;
  } rec_t;

  rec_t exp_q[$];
  rec_t sched[$];
  rec_t e;
  bit   cur_busy = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;

  function automatic rec_t mk(logic [5:0] c, logic h, logic b, logic s, logic r);
    rec_t t;
    t.ctrl = c; t.hilo = h; t.bsy = b; t.start = s; t.ready = r;
    return t;
  endfunction

  function automatic bit is_iter(logic [5:0] c);
`ifdef ALU_SEQ_MULTU_EN
    return (c == C_DIVU) || (c == C_MULTU);
`else
    return (c == C_DIVU);
`endif
  endfunction

  // Reference model: decides what the cycle after each edge should look like
  always @(posedge clk) begin
    if (!rst_n) begin
      sched.delete();
      e = mk(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    end else if (cur_busy) begin
      if (flush_in || sched.size() == 0) begin
        sched.delete();
        e = mk(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        e = sched.pop_front();
      end
    end else if (valid_in && !flush_in) begin
      if (is_iter(signal_in)) begin
        e = mk(signal_in, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < DW; i++) sched.push_back(mk(signal_in, 1'b0, 1'b1, 1'b0, 1'b0));
        sched.push_back(mk(HILO, 1'b1, 1'b1, 1'b0, 1'b0));
      end else begin
        e = mk(signal_in, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end else begin
      e = mk(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cur_busy = e.bsy;
    exp_q.push_back(e);
  end

  // Monitor: compare every presented cycle against the scoreboard head
  always @(negedge clk) begin
    rec_t x;
    cyc++;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      total++;
      if (ctrl_alu === x.ctrl && ctrl_sht === x.ctrl && ctrl_div === x.ctrl &&
          ctrl_mux === x.ctrl && hilo_we === x.hilo && busy === x.bsy &&
          start_pulse === x.start && ready_out === x.ready) begin
        passed++;
      end else begin
        $display("FAIL outputs cyc=%0d: got ctrl=%0d/%0d/%0d/%0d hilo_we=%b busy=%b start=%b ready=%b, expected ctrl=%0d hilo_we=%b busy=%b start=%b ready=%b",
                 cyc, ctrl_alu, ctrl_sht, ctrl_div, ctrl_mux, hilo_we, busy, start_pulse,
                 ready_out, x.ctrl, x.hilo, x.bsy, x.start, x.ready);
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] c, input logic f, input logic r);
    valid_in = v; signal_in = c; flush_in = f; rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, 1'b0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (ctrl_alu === NOP && ctrl_sht === NOP && ctrl_div === NOP && ctrl_mux === NOP &&
        hilo_we === 1'b0 && busy === 1'b0 && start_pulse === 1'b0 && ready_out === 1'b1) begin
      passed++;
    end else begin
      $display("FAIL reset state (%s): ctrl=%0d/%0d/%0d/%0d hilo_we=%b busy=%b start=%b ready=%b",
               tag, ctrl_alu, ctrl_sht, ctrl_div, ctrl_mux, hilo_we, busy, start_pulse, ready_out);
    end
  endtask

  task automatic wait_ready(input int max_cycles);
    int n;
    n = 0;
    while (ready_out !== 1'b1 && n < max_cycles) begin
      step(1'b0, NOP, 1'b0, 1'b1);
      n++;
    end
    total++;
    if (ready_out === 1'b1) begin
      passed++;
    end else begin
      $display("FAIL wait expired: ready_out not high within %0d cycles", max_cycles);
    end
  endtask

  logic [5:0] codes [10] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd27, 6'd16, 6'd18, 6'd25};

  initial begin
    step(1'b0, NOP, 1'b0, 1'b0);
    step(1'b1, C_ADD, 1'b1, 1'b0);
    check_reset_state("initial");
    // single-cycle ADD, then NOP
    step(1'b1, C_ADD, 1'b0, 1'b1);
    idle(3);
    // full DIVU run with AND held throughout
    step(1'b1, C_DIVU, 1'b0, 1'b1);
    for (int i = 0; i < DW + 3; i++) step(1'b1, C_AND, 1'b0, 1'b1);
    idle(2);
    // flush in RUN cycle 10, then a long quiet window
    step(1'b1, C_DIVU, 1'b0, 1'b1);
    idle(9);
    step(1'b1, C_AND, 1'b1, 1'b1);
    idle(40);
    // reset with flush in RUN cycle 20, then a clean DIVU
    step(1'b1, C_DIVU, 1'b0, 1'b1);
    idle(19);
    step(1'b1, C_AND, 1'b1, 1'b0);
    check_reset_state("mid-run");
    step(1'b1, C_DIVU, 1'b0, 1'b1);
    wait_ready(DW + 4);
    idle(2);
    // MULTU behaviour depends on the build
    step(1'b1, C_MULTU, 1'b0, 1'b1);
    idle(DW + 3);
    // flush in IDLE blocks accept; unknown codes pass through
    step(1'b1, C_ADD, 1'b1, 1'b1);
    step(1'b1, 6'd63, 1'b0, 1'b1);
    step(1'b1, 6'd50, 1'b0, 1'b1);
    // flush landing on the DONE cycle
    step(1'b1, C_DIVU, 1'b0, 1'b1);
    idle(DW);
    step(1'b0, NOP, 1'b1, 1'b1);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 2) != 0), c, ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 299) != 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
